// File: rtl/fir_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fir_stream_ctrl
//
// Sequencer wrapped around a single FIR filter instance. It turns a
// ready/valid sample stream into the filter's valid-only interface, which
// cannot stall. Samples are issued no faster than one per rate_div+1 cycles.
// Filter outputs are decimated by decim+1 and buffered in an output FIFO.
// An output is never lost under downstream backpressure, because a sample is
// issued only when a FIFO slot is guaranteed for its result. A flush pushes
// NUM_TAPS-1 zeros through the filter to drain its delay line.
//
// Optional build macro:
//   FIR_STREAM_CTRL_ERR_EN - adds the sticky 'err' output. It flags a filter
//                            output that arrives with nothing in flight, and
//                            a FIFO write into a full FIFO. Without the macro,
//                            such outputs are dropped silently.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   start, flush      - one-cycle command pulses (IDLE->RUN, RUN->FLUSH)
//   rate_div, decim   - issue pacing and decimation, captured at start
//   busy, done        - state != IDLE; one-cycle pulse at the end of a flush
//   s_valid/s_ready/s_data          - input sample stream
//   fir_valid_in/fir_din            - registered issue into the filter
//   fir_valid_out/fir_dout          - results from the filter
//   m_valid/m_ready/m_data          - decimated output stream
//   err (optional)                  - sticky protocol error flag
// ---------------------------------------------------------------------------
module fir_stream_ctrl #(
    parameter int INPUT_WIDTH    = 16,
    parameter int OUTPUT_WIDTH   = 26,
    parameter int NUM_TAPS       = 37,
    parameter int OUT_FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [7:0]              rate_div,
    input  logic [7:0]              decim,
    output logic                    busy,
    output logic                    done,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [INPUT_WIDTH-1:0]  s_data,
    output logic                    fir_valid_in,
    output logic [INPUT_WIDTH-1:0]  fir_din,
    input  logic                    fir_valid_out,
    input  logic [OUTPUT_WIDTH-1:0] fir_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUTPUT_WIDTH-1:0] m_data
`ifdef FIR_STREAM_CTRL_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int AW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int FW = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
    localparam logic [CW:0]   DEPTH_W    = (CW+1)'(OUT_FIFO_DEPTH);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(NUM_TAPS - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              rate_div_reg, rate_div_next;
    logic [7:0]              decim_reg, decim_next;
    logic [7:0]              pace_reg, pace_next;
    logic [7:0]              decim_cnt_reg, decim_cnt_next;
    logic [FW-1:0]           flush_cnt_reg, flush_cnt_next;
    logic [CW-1:0]           inflight_reg, inflight_next;
    logic [CW-1:0]           fifo_count_reg, fifo_count_next;
    logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic                    fir_valid_in_reg, fir_valid_in_next;
    logic [INPUT_WIDTH-1:0]  fir_din_reg, fir_din_next;
    logic                    done_reg, done_next;

    logic                    credit_ok, issue_ok, run_issue, flush_issue, issue;
    logic                    out_ok, keep, fifo_rd, fifo_wr, fifo_full;

    logic [OUTPUT_WIDTH-1:0] mem [OUT_FIFO_DEPTH];

`ifdef FIR_STREAM_CTRL_ERR_EN
    logic                    err_reg, err_next;
`endif

    always_comb begin
        state_next        = state_reg;
        rate_div_next     = rate_div_reg;
        decim_next        = decim_reg;
        pace_next         = pace_reg;
        decim_cnt_next    = decim_cnt_reg;
        flush_cnt_next    = flush_cnt_reg;
        inflight_next     = inflight_reg;
        fifo_count_next   = fifo_count_reg;
        done_next         = 1'b0;

        // Inflight counts a sample from the cycle it is issued, one cycle
        // before fir_valid_in shows it. This keeps the credit check exact
        // for back-to-back issue.
        credit_ok   = ({1'b0, inflight_reg} + {1'b0, fifo_count_reg}) < DEPTH_W;
        issue_ok    = (pace_reg == 8'd0) && credit_ok;
        s_ready     = (state_reg == ST_RUN) && issue_ok;
        run_issue   = s_ready && s_valid;
        flush_issue = (state_reg == ST_FLUSH) && issue_ok;
        issue       = run_issue || flush_issue;

        // With nothing in flight, a filter output is stale. That happens
        // after a reset mid-run. Such an output is ignored entirely.
        out_ok      = fir_valid_out && (inflight_reg != '0);
        keep        = out_ok && (decim_cnt_reg == 8'd0);
        fifo_rd     = (fifo_count_reg != '0) && m_ready;
        fifo_full   = (fifo_count_reg == CW'(OUT_FIFO_DEPTH));
        fifo_wr     = keep && (!fifo_full || fifo_rd);

        fir_valid_in_next = issue;
        fir_din_next      = run_issue ? s_data :
                            (flush_issue ? '0 : fir_din_reg);

        if (issue) begin
            pace_next = rate_div_reg;
        end else if (pace_reg != 8'd0) begin
            pace_next = pace_reg - 8'd1;
        end

        if (out_ok) begin
            decim_cnt_next = (decim_cnt_reg == 8'd0) ? decim_reg
                                                     : decim_cnt_reg - 8'd1;
        end

        case ({issue, out_ok})
            2'b10:   inflight_next = inflight_reg + CW'(1);
            2'b01:   inflight_next = inflight_reg - CW'(1);
            default: inflight_next = inflight_reg;
        endcase

        case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_next = fifo_count_reg + CW'(1);
            2'b01:   fifo_count_next = fifo_count_reg - CW'(1);
            default: fifo_count_next = fifo_count_reg;
        endcase

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_RUN;
                    rate_div_next  = rate_div;
                    decim_next     = decim;
                    pace_next      = 8'd0;
                    decim_cnt_next = 8'd0;
                    flush_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_issue) begin
                    if (flush_cnt_reg == FLUSH_LAST) begin
                        state_next = ST_DRAIN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg + FW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Judge on next-cycle occupancy. Then done arrives in the
                // cycle right after the last output leaves the FIFO.
                if ((inflight_next == '0) && (fifo_count_next == '0)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

`ifdef FIR_STREAM_CTRL_ERR_EN
        err_next = err_reg
                 | (fir_valid_out && (inflight_reg == '0))
                 | (keep && fifo_full && !fifo_rd);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            rate_div_reg     <= 8'd0;
            decim_reg        <= 8'd0;
            pace_reg         <= 8'd0;
            decim_cnt_reg    <= 8'd0;
            flush_cnt_reg    <= '0;
            inflight_reg     <= '0;
            fifo_count_reg   <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fir_valid_in_reg <= 1'b0;
            fir_din_reg      <= '0;
            done_reg         <= 1'b0;
`ifdef FIR_STREAM_CTRL_ERR_EN
            err_reg          <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            rate_div_reg     <= rate_div_next;
            decim_reg        <= decim_next;
            pace_reg         <= pace_next;
            decim_cnt_reg    <= decim_cnt_next;
            flush_cnt_reg    <= flush_cnt_next;
            inflight_reg     <= inflight_next;
            fifo_count_reg   <= fifo_count_next;
            fir_valid_in_reg <= fir_valid_in_next;
            fir_din_reg      <= fir_din_next;
            done_reg         <= done_next;
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
`ifdef FIR_STREAM_CTRL_ERR_EN
            err_reg          <= err_next;
`endif
        end
    end

    // FIFO storage has no reset. Resetting the pointers and the count is
    // enough to empty it.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg] <= fir_dout;
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign done         = done_reg;
    assign fir_valid_in = fir_valid_in_reg;
    assign fir_din      = fir_din_reg;
    assign m_valid      = (fifo_count_reg != '0);
    // Force m_data to zero when the FIFO is empty, so the output never
    // exposes stale or uninitialised storage.
    assign m_data       = m_valid ? mem[rd_ptr_reg] : '0;

`ifdef FIR_STREAM_CTRL_ERR_EN
    assign err          = err_reg;
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_ctrl
//
// Directed bench for fir_stream_ctrl. A stand-in filter is a plain 8-cycle
// pipeline, and its output is input + 0x1000. A source process feeds queued
// samples over the ready/valid port. Each accepted sample pushes its expected
// result into a scoreboard queue, with decimation applied. A monitor pops and
// compares on every m_valid && m_ready.
// ---------------------------------------------------------------------------
module tb_fir_stream_ctrl;

    localparam logic [25:0] OFFSET  = 26'h0001000;
    localparam logic [25:0] INJ_VAL = 26'h2ABCDEF;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [7:0]  rate_div, decim;
    logic        busy, done;
    logic        s_valid, s_ready;
    logic [15:0] s_data;
    logic        fir_valid_in;
    logic [15:0] fir_din;
    logic        fir_valid_out;
    logic [25:0] fir_dout;
    logic        m_valid, m_ready;
    logic [25:0] m_data;
`ifdef FIR_STREAM_CTRL_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    fir_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .rate_div(rate_div), .decim(decim), .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_valid_in(fir_valid_in), .fir_din(fir_din),
        .fir_valid_out(fir_valid_out), .fir_dout(fir_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIR_STREAM_CTRL_ERR_EN
        , .err(err)
`endif
    );

    // Stand-in filter: 8-cycle latency. It ignores rst, so results still in
    // flight at reset come out later.
    logic        model_clr, inject_vo;
    logic [7:0]  model_vld;
    logic [25:0] model_dat [8];

    always @(posedge clk) begin
        if (model_clr) model_vld <= '0;
        else           model_vld <= {model_vld[6:0], fir_valid_in};
        model_dat[0] <= 26'(fir_din) + OFFSET;
        for (int i = 1; i < 8; i++) model_dat[i] <= model_dat[i-1];
    end

    assign fir_valid_out = model_vld[7] | inject_vo;
    assign fir_dout      = model_vld[7] ? model_dat[7] : INJ_VAL;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared bench state
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] src_q [$];
    logic [25:0] exp_q [$];
    int          hs_cyc_q [$];
    int          fvi_cyc_q [$];
    int          exp_idx, cur_decim;
    int          pop_cnt, bench_inflight, max_inflight;
    int          flush_zero_cnt, flush_sready_cnt, done_cnt, done_cyc, last_rd_cyc;
    logic        done_busy, in_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] d);
        if ((exp_idx % (cur_decim + 1)) == 0) exp_q.push_back(26'(d) + OFFSET);
        exp_idx++;
    endtask

    task automatic monitor_loop();
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                bench_inflight = 0;
                continue;
            end
            if (fir_valid_in) begin
                fvi_cyc_q.push_back(cyc);
                bench_inflight++;
                if (in_flush && fir_din == 16'd0) flush_zero_cnt++;
            end
            if (fir_valid_out && bench_inflight > 0) bench_inflight--;
            if (bench_inflight > max_inflight) max_inflight = bench_inflight;
            if (in_flush && s_ready) flush_sready_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (m_valid && m_ready) begin
                n_vec++;
                pop_cnt++;
                last_rd_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: got m_data=%h, required no output", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        n_err++;
                        $display("FAIL out_data: got m_data=%h, required %h", m_data, e);
                    end else begin
                        $display("txn %0d: m_data=%h", pop_cnt, m_data);
                    end
                end
            end
        end
    endtask

    task automatic source_loop();
        logic        hs;
        logic [15:0] hd;
        int          hc;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            hs = s_valid && s_ready;
            hd = s_data;
            hc = cyc;
            @(posedge clk);
            #1;
            if (hs && !rst) begin
                hs_cyc_q.push_back(hc);
                if (src_q.size() > 0) void'(src_q.pop_front());
                push_exp(hd);
            end
            if (src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
        end
    endtask

    task automatic clear_stats();
        hs_cyc_q.delete();
        fvi_cyc_q.delete();
        pop_cnt = 0; max_inflight = 0;
        flush_zero_cnt = 0; flush_sready_cnt = 0;
        done_cnt = 0; done_cyc = -1; last_rd_cyc = -1; done_busy = 1'b1;
    endtask

    task automatic start_run(input logic [7:0] r, input logic [7:0] d);
        @(posedge clk); #1;
        start = 1'b1; rate_div = r; decim = d;
        cur_decim = int'(d); exp_idx = 0;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!(src_q.size() == 0 && !s_valid && exp_q.size() == 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= budget) begin
            n_err++;
            $display("FAIL %s: got timeout after %0d cycles (%0d outputs pending), required drain", name, k, exp_q.size());
        end
    endtask

    task automatic end_phase();
        repeat (12) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        src_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_done"},         done,         0);
        check({tag, "_s_ready"},      s_ready,      0);
        check({tag, "_fir_valid_in"}, fir_valid_in, 0);
        check({tag, "_fir_din"},      fir_din,      0);
        check({tag, "_m_valid"},      m_valid,      0);
        check({tag, "_m_data"},       m_data,       0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int mv_seen;
        rst = 1'b1; model_clr = 1'b1; start = 1'b0; flush = 1'b0;
        rate_div = 8'd0; decim = 8'd0; m_ready = 1'b1; inject_vo = 1'b0;
        in_flush = 1'b0; cur_decim = 0; exp_idx = 0; bench_inflight = 0;
        clear_stats();
        fork
            monitor_loop();
            source_loop();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        model_clr = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;

        // 1: full rate, no decimation, 100 samples
        start_run(8'd0, 8'd0);
        check("start_busy",    busy,    1);
        check("start_s_ready", s_ready, 1);
        for (int i = 0; i < 100; i++) src_q.push_back(16'(i * 7 + 1));
        wait_idle(400, "p1_drain");
        check("p1_hs_count",  hs_cyc_q.size(), 100);
        check("p1_hs_span",   hs_cyc_q[$] - hs_cyc_q[0], 99);
        check("p1_fvi_count", fvi_cyc_q.size(), 100);
        check("p1_fvi_span",  fvi_cyc_q[$] - fvi_cyc_q[0], 99);
        check("p1_inflight_range", (max_inflight >= 8 && max_inflight <= 9), 1);
        check("p1_outputs",   pop_cnt, 100);
        end_phase();

        // 2: rate_div = 3 -> one issue every 4 cycles
        start_run(8'd3, 8'd0);
        for (int i = 0; i < 12; i++) src_q.push_back(16'h0A00 + 16'(i));
        wait_idle(200, "p2_drain");
        check("p2_hs_count",  hs_cyc_q.size(), 12);
        for (int i = 1; i < hs_cyc_q.size(); i++)
            check("p2_hs_gap", hs_cyc_q[i] - hs_cyc_q[i-1], 4);
        for (int i = 1; i < fvi_cyc_q.size(); i++)
            check("p2_fvi_gap", fvi_cyc_q[i] - fvi_cyc_q[i-1], 4);
        end_phase();

        // 3: decim = 2, 30 samples -> filter outputs 0,3,...,27
        start_run(8'd0, 8'd2);
        for (int i = 0; i < 30; i++) src_q.push_back(16'd200 + 16'(i));
        wait_idle(200, "p3_drain");
        check("p3_outputs", pop_cnt, 10);
        end_phase();

        // 4: backpressure -> exactly OUT_FIFO_DEPTH issued, none lost
        start_run(8'd0, 8'd0);
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) src_q.push_back(16'h5000 + 16'(i));
        repeat (60) @(negedge clk);
        check("p4_hs_blocked", hs_cyc_q.size(), 16);
        check("p4_s_ready",    s_ready, 0);
        check("p4_m_valid",    m_valid, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle(200, "p4_drain");
        check("p4_outputs", pop_cnt, 20);
        end_phase();

        // 5: flush after 5 samples
        start_run(8'd0, 8'd0);
        for (int i = 0; i < 5; i++) src_q.push_back(16'h0300 + 16'(i));
        k = 0;
        while ((src_q.size() != 0 || s_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("p5_sent", (k < 50), 1);
        @(posedge clk); #1;
        flush = 1'b1;
        for (int i = 0; i < 36; i++) push_exp(16'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_flush = 1'b1;
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("p5_done_seen", (done_cnt != 0), 1);
        repeat (5) @(negedge clk);
        in_flush = 1'b0;
        check("p5_zero_issues",   flush_zero_cnt, 36);
        check("p5_s_ready_flush", flush_sready_cnt, 0);
        check("p5_done_pulses",   done_cnt, 1);
        check("p5_done_timing",   done_cyc - last_rd_cyc, 1);
        check("p5_done_busy",     done_busy, 0);
        check("p5_busy_after",    busy, 0);
        check("p5_outputs",       pop_cnt, 41);
        check("p5_scoreboard",    exp_q.size(), 0);

        // 6: reset mid-run with 4 results in flight
        start_run(8'd0, 8'd0);
        for (int i = 0; i < 4; i++) src_q.push_back(16'h0700 + 16'(i));
        k = 0;
        while (fvi_cyc_q.size() < 4 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("p6_issued", fvi_cyc_q.size(), 4);
        #1 rst = 1'b1;
        exp_q.delete();
        src_q.delete();
        #1;
        check_reset_outputs("rst_mid");
        repeat (15) @(negedge clk);
        #1 rst = 1'b0;
        mv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) mv_seen++;
        end
        check("p6_late_dropped", mv_seen, 0);
`ifdef FIR_STREAM_CTRL_ERR_EN
        check("p6_err_clear", err, 0);
`endif
        @(posedge clk); #1;
        inject_vo = 1'b1;
        @(posedge clk); #1;
        inject_vo = 1'b0;
        repeat (3) @(negedge clk);
        check("p6_inject_dropped", m_valid, 0);
        check("p6_inject_busy",    busy, 0);
`ifdef FIR_STREAM_CTRL_ERR_EN
        check("p6_err_set", err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Sequencer placed in front of and behind one `FirFilter` instance. It converts a ready/valid sample stream into the filter's valid-only, non-stallable interface, and paces sample issue at a run-time rate. It decimates filter outputs and guarantees that no output is lost under downstream backpressure by using credit-based issue against an output FIFO. A flush sequence drains the filter's delay line with zeros.

## Interface
Parameters:
- `INPUT_WIDTH`, 16, sample width into the filter
- `OUTPUT_WIDTH`, 26, filter output width
- `NUM_TAPS`, 37, filter tap count; sets the flush length
- `OUT_FIFO_DEPTH`, 16, output FIFO entries, power of two ≥ 2

Ports:
- `clk` in 1: the single clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle pulse; IDLE→RUN
- `flush` in 1: one-cycle pulse; RUN→FLUSH
- `rate_div` in 8: issue at most one sample per `rate_div+1` cycles; sampled at `start`
- `decim` in 8: keep one output per `decim+1`; sampled at `start`
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse when flush completes
- `s_valid` in 1, `s_ready` out 1, `s_data` in INPUT_WIDTH: input stream
- `fir_valid_in` out 1, `fir_din` out INPUT_WIDTH: to the filter
- `fir_valid_out` in 1, `fir_dout` in OUTPUT_WIDTH: from the filter
- `m_valid` out 1, `m_ready` in 1, `m_data` out OUTPUT_WIDTH: output stream

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: `flush` → FLUSH.
  - FLUSH: after NUM_TAPS−1 zero samples are issued → DRAIN.
  - DRAIN: when `inflight`==0 and the FIFO is empty, pulse `done` and go to IDLE.
- `start` outside IDLE and `flush` outside RUN are ignored.
- `inflight` counter, range 0..OUT_FIFO_DEPTH:
  - +1 per `fir_valid_in`, −1 per `fir_valid_out`.
  - Both in the same cycle leave it unchanged.
- Credit rule: issue only when `inflight + fifo_count < OUT_FIFO_DEPTH`.
- Pace counter:
  - Loads `rate_div` on each issue and decrements to 0.
  - Issue is permitted only at 0.
  - Cleared at `start`.
- `s_ready` = RUN && pace==0 && credit. The handshake is `s_valid && s_ready`.
- In FLUSH, the same pace and credit gating applies; zeros are issued and `s_ready`=0.
- Decimation counter:
  - Cleared at `start`; counts every `fir_valid_out`.
  - An output is written to the FIFO when the counter is 0; the counter then reloads `decim`.
  - Discarded outputs still release credit.
- FIFO:
  - Write on a kept `fir_valid_out`; read on `m_valid && m_ready`.
  - Simultaneous read and write at full or empty is legal.
  - Overflow is impossible by the credit rule.
- Throughput of one sample per `rate_div+1` cycles requires OUT_FIFO_DEPTH > filter latency / (rate_div+1).
- Reset mid-operation: state IDLE, all counters 0, FIFO emptied; in-flight filter outputs arriving after reset are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `s_ready`=0, `fir_valid_in`=0, `fir_din`=0, `m_valid`=0, `m_data`=0.
- `fir_valid_in`/`fir_din` are registered: a handshake at cycle t gives `fir_valid_in`=1 at t+1. Flush zeros use the same timing.
- Kept `fir_valid_out` at cycle t → `m_valid` at t+1 if the FIFO was empty.
- `start` at t → `busy`=1 and `s_ready` eligible at t+1.
- `done` is asserted in the cycle the state returns to IDLE; `busy` is 0 in that same cycle.

## Configuration
- `FIR_STREAM_CTRL_ERR_EN` defined: adds output `err` (1 bit, reset 0, sticky until `rst`).
  - Sets on `fir_valid_out` when `inflight`==0.
  - Sets on a FIFO write when the FIFO is full.
- Undefined: no `err` port and no checking logic; these conditions are silently ignored (the output is dropped).

## Test plan
- `rate_div`=0, `decim`=0, `m_ready`=1, filter model latency 8, stream 100 samples → 100 outputs in order; `fir_valid_in` back-to-back; `inflight` ≤ 9.
- `rate_div`=3 → `fir_valid_in` exactly every 4th cycle; `s_ready` high 1 cycle in 4 while `s_valid`=1.
- `decim`=2, 30 samples → 10 outputs: filter outputs 0, 3, …, 27.
- `m_ready`=0, OUT_FIFO_DEPTH=16 → exactly 16 samples issued, then `s_ready`=0; release `m_ready` → all 16 delivered, none lost.
- `flush` after 5 samples → 36 zero issues with `s_ready`=0; `done` one cycle after the last output is read; `busy`=0.
- Assert `rst` mid-RUN with 4 outputs in flight → all outputs at reset values immediately; late filter outputs not forwarded; `err` (ERR_EN) stays 0 after reset deassertion. The same `fir_valid_out` injected with `inflight`=0 while `rst` is deasserted → `err`=1.
